// File: rtl/i2s_pkg.sv
// Shared I2S link constants and slave FSM encoding.
// The slot constants are common to the slave endpoint and the transceiver-side master.
package i2s_pkg;

  localparam int I2S_SLOT_BITS = 32;  // BCLK periods per LRCLK half-frame
  localparam int I2S_RX_WIDTH  = 24;  // received sample width per channel
  localparam int I2S_TX_WIDTH  = 16;  // transmitted sample width per channel

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// Input conditioning for the I2S bus pins.
// Brings BCLK, LRCLK and SDIN into the clk domain through 2-FF synchronisers
// and detects rising/falling edges of the synchronised BCLK.
// Ports:
//   clk, _reset            system clock, async active-low reset
//   bclk, lrclk, sdin      raw bus pins (asynchronous to clk)
//   bclk_rise, bclk_fall   one-clk pulses on synchronised BCLK edges
//   lrclk_sync, sdin_sync  synchronised LRCLK / SDIN, aligned with the edge pulses
module i2s_edge_sync (
  input  logic clk,
  input  logic _reset,
  input  logic bclk,
  input  logic lrclk,
  input  logic sdin,
  output logic bclk_rise,
  output logic bclk_fall,
  output logic lrclk_sync,
  output logic sdin_sync
);

  logic [1:0] bclk_ff;
  logic [1:0] lrclk_ff;
  logic [1:0] sdin_ff;
  logic       bclk_last;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      bclk_ff   <= 2'b00;
      lrclk_ff  <= 2'b00;
      sdin_ff   <= 2'b00;
      bclk_last <= 1'b0;
    end else begin
      bclk_ff   <= {bclk_ff[0], bclk};
      lrclk_ff  <= {lrclk_ff[0], lrclk};
      sdin_ff   <= {sdin_ff[0], sdin};
      bclk_last <= bclk_ff[1];
    end
  end

  // All three pins share the same synchroniser depth, so LRCLK/SDIN seen
  // alongside a BCLK edge pulse are the values present at that bus edge.
  assign bclk_rise  = bclk_ff[1] & ~bclk_last;
  assign bclk_fall  = ~bclk_ff[1] & bclk_last;
  assign lrclk_sync = lrclk_ff[1];
  assign sdin_sync  = sdin_ff[1];

endmodule

// File: rtl/i2s_slave_endpoint.sv
// I2S slave endpoint: follows master BCLK/LRCLK, deserialises RX_WIDTH-bit
// left/right (I/Q) samples from SDIN and serialises TX_WIDTH-bit samples on SDOUT.
// Ports:
//   clk, _reset          system clock (>= 8x BCLK), async active-low reset
//   BCLK, LRCLK, SDIN    bus inputs from the master
//   SDOUT                serial data to the master, changes on falling BCLK
//   rx_real, rx_imag     last complete left/right sample pair
//   rx_valid             one-clk pulse when rx_real/rx_imag update
//   tx_real, tx_imag     samples to send, captured at frame start
//   tx_load              one-clk pulse when tx_real/tx_imag are captured
//   frame_err            one-clk pulse on a slot-length violation
//
// state | meaning
// SYNC  | waiting for an LRCLK high->low boundary, SDOUT held 0
// LEFT  | receiving/sending the left (real) slot
// RIGHT | receiving/sending the right (imag) slot
module i2s_slave_endpoint
  import i2s_pkg::*;
#(
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int RX_WIDTH  = I2S_RX_WIDTH,
  parameter int TX_WIDTH  = I2S_TX_WIDTH
) (
  input  logic                clk,
  input  logic                _reset,
  input  logic                BCLK,
  input  logic                LRCLK,
  input  logic                SDIN,
  output logic                SDOUT,
  output logic [RX_WIDTH-1:0] rx_real,
  output logic [RX_WIDTH-1:0] rx_imag,
  output logic                rx_valid,
  input  logic [TX_WIDTH-1:0] tx_real,
  input  logic [TX_WIDTH-1:0] tx_imag,
  output logic                tx_load,
  output logic                frame_err
);

  // Two spare bits so over-long slots stay distinguishable before saturating.
  localparam int POS_W = $clog2(SLOT_BITS) + 2;
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(SLOT_BITS - 1);
  localparam logic [POS_W-1:0] POS_RX_END = POS_W'(RX_WIDTH);

  logic bclk_rise;
  logic bclk_fall;
  logic lrclk_sync;
  logic sdin_sync;

  i2s_edge_sync u_edge_sync (
    .clk        (clk),
    ._reset     (_reset),
    .bclk       (BCLK),
    .lrclk      (LRCLK),
    .sdin       (SDIN),
    .bclk_rise  (bclk_rise),
    .bclk_fall  (bclk_fall),
    .lrclk_sync (lrclk_sync),
    .sdin_sync  (sdin_sync)
  );

  i2s_state_t state_q, state_d;

  logic                lr_prev_q;
  logic [POS_W-1:0]    pos_q;
  logic [RX_WIDTH-1:0] shift_q;
  logic [RX_WIDTH-1:0] hold_q;
  logic [TX_WIDTH-1:0] tx_real_q;
  logic [TX_WIDTH-1:0] tx_imag_q;
  logic [TX_WIDTH-1:0] tx_word;
  logic [TX_WIDTH-1:0] tx_shift;
  logic                sdout_q;

  logic boundary;
  logic slot_ok;
  logic hold_en;
  logic rx_en;
  logic tx_cap;
  logic err_det;

  assign boundary = lrclk_sync != lr_prev_q;
  // pos_q is the position of the last edge of the slot being closed, so an
  // exact-length slot ends at SLOT_BITS-1.
  assign slot_ok  = pos_q == POS_LAST;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) state_q <= SYNC;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    hold_en = 1'b0;
    rx_en   = 1'b0;
    tx_cap  = 1'b0;
    err_det = 1'b0;
    if (bclk_rise && boundary) begin
      case (state_q)
        SYNC: begin
          if (!lrclk_sync) begin
            state_d = LEFT;
            tx_cap  = 1'b1;
          end
        end
        LEFT: begin
          if (!slot_ok) begin
            err_det = 1'b1;
            state_d = SYNC;
          end else begin
            hold_en = 1'b1;
            state_d = RIGHT;
          end
        end
        RIGHT: begin
          if (!slot_ok) begin
            err_det = 1'b1;
            state_d = SYNC;
          end else begin
            rx_en   = 1'b1;
            tx_cap  = 1'b1;
            state_d = LEFT;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // Outgoing bit for position pos_q+1: shifting by pos_q puts it at the MSB,
  // and positions beyond TX_WIDTH shift out to 0.
  assign tx_word  = lr_prev_q ? tx_imag_q : tx_real_q;
  assign tx_shift = tx_word << pos_q;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      lr_prev_q <= 1'b0;
      pos_q     <= '0;
      shift_q   <= '0;
      hold_q    <= '0;
      tx_real_q <= '0;
      tx_imag_q <= '0;
      sdout_q   <= 1'b0;
      rx_real   <= '0;
      rx_imag   <= '0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      frame_err <= err_det;

      if (bclk_rise) begin
        lr_prev_q <= lrclk_sync;
        if (boundary)
          pos_q <= '0;
        else if (pos_q != '1)
          pos_q <= pos_q + 1'b1;
        // Data occupies positions 1..RX_WIDTH (one-bit I2S delay after the boundary).
        if (!boundary && (pos_q < POS_RX_END))
          shift_q <= {shift_q[RX_WIDTH-2:0], sdin_sync};
      end

      if (hold_en)
        hold_q <= shift_q;

      if (rx_en) begin
        rx_real  <= hold_q;
        rx_imag  <= shift_q;
        rx_valid <= 1'b1;
      end

      if (tx_cap) begin
        tx_real_q <= tx_real;
        tx_imag_q <= tx_imag;
        tx_load   <= 1'b1;
      end

      if (bclk_fall)
        sdout_q <= (state_q == SYNC) ? 1'b0 : tx_shift[TX_WIDTH-1];
    end
  end

  assign SDOUT = sdout_q;

endmodule

// File: doc/i2s_slave_endpoint.md
Name: i2s_slave_endpoint

Overview:
- Counterpart of the transceiver's I2S master: the slave end of the same I2S link.
- Follows externally supplied BCLK/LRCLK.
- Deserialises the 24-bit I/Q receive samples arriving on SDIN.
- Serialises 16-bit I/Q transmit samples onto SDOUT.
- Used as an FPGA-side loopback/bring-up partner and as the reference slave in board-level benches.
- All logic runs on one system clock that oversamples the I2S bus.

Parameters:
- SLOT_BITS, 32: BCLK periods per LRCLK half-frame (one channel slot).
- RX_WIDTH, 24: received sample width per channel.
- TX_WIDTH, 16: transmitted sample width per channel.

Ports:
- clk  in  1  system clock; frequency must be at least 8x BCLK.
- _reset  in  1  asynchronous, active-low reset.
- BCLK  in  1  I2S bit clock from the master; asynchronous to clk.
- LRCLK  in  1  I2S word select from the master; low = left/real, high = right/imag.
- SDIN  in  1  serial data from the master.
- SDOUT  out  1  serial data to the master.
- rx_real  out  RX_WIDTH  last complete left-slot sample.
- rx_imag  out  RX_WIDTH  last complete right-slot sample.
- rx_valid  out  1  one-clk pulse when rx_real/rx_imag update.
- tx_real  in  TX_WIDTH  left-slot sample to send; sampled at frame start.
- tx_imag  in  TX_WIDTH  right-slot sample to send; sampled at frame start.
- tx_load  out  1  one-clk pulse when tx_real/tx_imag are captured.
- frame_err  out  1  one-clk pulse on a slot-length violation.

Behaviour:
- Reset (_reset low): all outputs 0, state SYNC, shift registers and counters cleared. Reset asserted mid-frame aborts the frame with no partial rx_valid.
- Input conditioning: BCLK, LRCLK and SDIN each pass through a 2-FF synchroniser, followed by a rise/fall detector on the synchronised BCLK. All bus events are judged on synchronised values, giving a fixed 3-clk lag.
- Rising BCLK edge:
  - Sample LRCLK and SDIN.
  - If sampled LRCLK differs from its value at the previous rising edge, this is a boundary edge: position p = 0. Otherwise p increments.
  - Data bits occupy p = 1..RX_WIDTH, MSB first (standard I2S one-bit delay). SDIN at all other positions is ignored.
- Falling BCLK edge: drive SDOUT with the bit for position p+1. TX bits are MSB first at p+1 = 1..TX_WIDTH, 0 elsewhere. SDOUT changes only on a falling-edge detect.
- Slot length: at every boundary edge the previous slot must have contained exactly SLOT_BITS rising edges. If not:
  - frame_err pulses.
  - The current frame's rx_valid is suppressed.
  - The FSM returns to SYNC.
- FSM states:
  - SYNC: SDOUT = 0, no rx_valid/tx_load. Leaves on the first LRCLK high->low boundary (start of a left slot) and enters LEFT. The length check is skipped for this first boundary.
  - LEFT: leaves on a low->high boundary; latch the left shift register into a holding register; go to RIGHT.
  - RIGHT: leaves on a high->low boundary; go to LEFT and, in the same clk:
    - drive rx_real = holding register and rx_imag = right shift register, with rx_valid = 1;
    - capture tx_real/tx_imag, with tx_load = 1.
  - On entering LEFT from SYNC, also capture tx_real/tx_imag and pulse tx_load, without rx_valid.
- Latency: rx_valid asserts 3-4 clk after the BCLK rising edge that carries the LRCLK falling boundary. The captured tx word is first driven at the next falling BCLK detect.
- Outputs hold between rx_valid pulses. tx_real/tx_imag changing mid-frame has no effect.
- Simultaneous boundary and length error: the error wins; no rx_valid and no tx_load are issued for that edge.
- LRCLK glitch shorter than one BCLK: appears as two boundaries, fails the length check, and is handled as a frame_err.

Decomposition:
- Shared package i2s_pkg: SLOT_BITS/RX_WIDTH/TX_WIDTH defaults and the FSM state encoding (SYNC, LEFT, RIGHT). The transceiver-side I2S master uses the same slot constants.
- One sub-module, i2s_edge_sync: 2-FF synchroniser plus rise/fall detector. Instantiated for BCLK, with plain synchronised outputs for LRCLK and SDIN.

Test Plan:
- Nominal frame: clk 122.88 MHz, BCLK 3.072 MHz, 32-bit slots. Master sends real = 24'h5A5A5A, imag = 24'hA5A5A5 -> after the third LRCLK falling boundary, rx_real = 24'h5A5A5A, rx_imag = 24'hA5A5A5, with exactly one rx_valid per frame.
- TX path: tx_real = 16'h8001, tx_imag = 16'h7FFE held -> master captures 32'h80010000 (left) and 32'h7FFE0000 (right). Bits after position 16 are 0.
- Start-up sync: release _reset mid right slot -> SDOUT stays 0 and no rx_valid until the first left slot. tx_load fires at that first left slot; the first rx_valid comes one frame later.
- Short slot: one left slot of 31 BCLKs -> frame_err pulses once, no rx_valid for that frame, FSM returns to SYNC. Correct rx_valid resumes after one complete frame.
- Reset mid-frame: assert _reset at p = 12 of a right slot -> all outputs 0 within the reset assertion, no rx_valid pulse, and clean resync afterwards.
- Back-to-back sample changes: tx_real changed at p = 8 of a left slot -> the current frame still transmits the old word; the new word goes out next frame.
